looper_boot_ctrl: RTL and testbench
===================================

Name: looper_boot_ctrl

Overview:
Boot/restart sequencer that sits directly upstream of top_module_looper and drives its extern_pc / extern_pc_en load port plus a core reset.
- After system reset it holds the core in reset, then presents a start PC with a load strobe, then releases the core to run.
- A debounced board push-button later restarts the core at a PC selected by board switches.
- Runs in the core clock domain (10 MHz).

Parameters:
PC_W, 15, width of the program counter
BOOT_PC, 15'h0000, PC loaded after system reset
HOLD_CYCLES, 16, cycles core_rst_n is held low per boot (>=1)
LOAD_CYCLES, 2, cycles extern_pc_en is asserted per boot (>=1)
DB_CYCLES, 100000, consecutive stable cycles needed before the debounced button level changes (>=2)

Ports:
clk  in  1  core clock; all logic on its rising edge
rst  in  1  reset, synchronous, active-high
restart_btn  in  1  raw asynchronous push-button, active-high
restart_pc  in  PC_W  PC used on button restart; sampled at trigger
core_rst_n  out  1  active-low reset to the core
extern_pc  out  PC_W  PC value to the core load port
extern_pc_en  out  1  load strobe to the core
boot_done  out  1  high while the core is running
boot_count  out  8  number of completed boots, saturating

Behaviour:
Outputs and reset
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- While rst=1 the block is in state HOLD with: core_rst_n=0, extern_pc=BOOT_PC, extern_pc_en=0, boot_done=0, boot_count=0, hold/load counters=0.
- Debounce state is also reset: sync flops=0, debounced level=0, debounce counter=0.
- rst asserted mid-operation in any state forces this reset state on the next edge, and the boot restarts from BOOT_PC.

FSM states: HOLD -> LOAD -> RUN
- HOLD:
  - Outputs: core_rst_n=0, extern_pc_en=0, boot_done=0.
  - The counter increments each cycle; at count == HOLD_CYCLES-1, clear the counter and go to LOAD.
  - Result: exactly HOLD_CYCLES edges in HOLD, counted from the first edge with rst=0.
- LOAD:
  - Outputs: core_rst_n=1, extern_pc_en=1, extern_pc stable.
  - After LOAD_CYCLES cycles, go to RUN and increment boot_count (saturating at 8'hFF).
- RUN:
  - Outputs: core_rst_n=1, extern_pc_en=0, boot_done=1.
  - extern_pc holds its last value.
  - A restart trigger loads extern_pc <= restart_pc and moves to HOLD on the same edge.

Restart trigger
- restart_btn passes through a 2-flop synchronizer.
- The debounce counter resets whenever the synchronized value equals the debounced level.
- Otherwise the counter increments; when it reaches DB_CYCLES-1, the debounced level takes the synchronized value.
- Trigger = one-cycle rising edge of the debounced level.
- Triggers in HOLD or LOAD are ignored (not queued).
- The debounced level keeps tracking in all states, so a button held through a boot never fires again until it is released and pressed again.
- Glitches shorter than DB_CYCLES cycles produce no trigger.
- Latency from a clean press to the trigger is 2 + DB_CYCLES cycles.

Width rules
- extern_pc is exactly PC_W bits, with no arithmetic applied.
- boot_count never wraps.

Decomposition:
- Package looper_boot_pkg holds:
  - the state enum (HOLD, LOAD, RUN)
  - PC_W default constant
  - BOOT_CNT_W = 8
- Sub-module btn_debounce (params DB_CYCLES; ports clk, rst, btn_raw, level, rise) contains the synchronizer and debounce logic.
- The FSM and counters live in looper_boot_ctrl.

Test Plan:
(HOLD_CYCLES=16, LOAD_CYCLES=2, DB_CYCLES=4, BOOT_PC=15'h0010)
1. Release rst at edge 0 -> core_rst_n=0 through edge 15; at edges 16-17 core_rst_n=1, extern_pc_en=1, extern_pc=15'h0010; from edge 18 extern_pc_en=0, boot_done=1, boot_count=1.
2. In RUN, restart_pc=15'h1234, press button held 10 cycles -> trigger 6 cycles after press; state HOLD with core_rst_n=0 and extern_pc=15'h1234; 18 cycles later boot_done=1 and boot_count=2; exactly one restart occurs.
3. Button pulses 1, 2 and 3 cycles wide, separated by idle gaps -> no trigger, boot_done stays 1, boot_count unchanged.
4. Button pressed during HOLD and held into RUN -> no restart; release, then press again for 6 cycles -> exactly one restart.
5. Assert rst for 1 cycle during LOAD with extern_pc=15'h1234 -> next edge core_rst_n=0, extern_pc=15'h0010, boot_count=0; the full boot sequence repeats.
6. Force 256 restarts -> boot_count reads 8'hFF after the 255th and 256th, and never wraps to 0.

Source files
------------

// File: rtl/looper_boot_pkg.sv
// Shared types and constants for the looper boot/restart sequencer.
// Boot FSM encoding plus a saturating boot-counter helper.
package looper_boot_pkg;

   localparam int PC_W_DFLT  = 15;
   localparam int BOOT_CNT_W = 8;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } boot_state_e;

   function automatic logic [BOOT_CNT_W-1:0] sat_inc(input logic [BOOT_CNT_W-1:0] v);
      return (v == {BOOT_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer + debouncer: level follows btn_raw after DB_CYCLES stable cycles.
// Latency 2 + DB_CYCLES cycles from a clean edge to level/rise; rise is a one-cycle registered pulse.
module btn_debounce #(
   parameter int DB_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
         // Input has disagreed with the level long enough: accept it.
         cnt_d   = '0;
         level_d = sync2_q;
         rise_d  = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/looper_boot_ctrl.sv
// Boot/restart sequencer feeding the looper core's PC load port and reset: HOLD -> LOAD -> RUN.
// Boot takes HOLD_CYCLES + LOAD_CYCLES cycles; outputs are register-decoded and no backpressure exists.
module looper_boot_ctrl
   import looper_boot_pkg::*;
#(
   parameter int              PC_W        = PC_W_DFLT,
   parameter logic [PC_W-1:0] BOOT_PC     = '0,
   parameter int              HOLD_CYCLES = 16,
   parameter int              LOAD_CYCLES = 2,
   parameter int              DB_CYCLES   = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  restart_btn,
   input  logic [PC_W-1:0]       restart_pc,
   output logic                  core_rst_n,
   output logic [PC_W-1:0]       extern_pc,
   output logic                  extern_pc_en,
   output logic                  boot_done,
   output logic [BOOT_CNT_W-1:0] boot_count
);

   localparam int CNT_MAX = (HOLD_CYCLES > LOAD_CYCLES) ? HOLD_CYCLES : LOAD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);

   boot_state_e           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [PC_W-1:0]       pc_q, pc_d;
   logic [BOOT_CNT_W-1:0] bcnt_q, bcnt_d;

   logic db_level;
   logic db_rise;
   logic trig;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_btn_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (restart_btn),
      .level   (db_level),
      .rise    (db_rise)
   );

   assign trig = db_rise & db_level;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOAD: begin
            if (cnt_q == LOAD_LAST) begin
               cnt_d   = '0;
               state_d = RUN;
               bcnt_d  = sat_inc(bcnt_q);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            // Triggers outside RUN are simply dropped; the debouncer keeps tracking.
            if (trig) begin
               pc_d    = restart_pc;
               cnt_d   = '0;
               state_d = HOLD;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = HOLD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         pc_q    <= BOOT_PC;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign core_rst_n   = (state_q != HOLD);
   assign extern_pc_en = (state_q == LOAD);
   assign boot_done    = (state_q == RUN);
   assign extern_pc    = pc_q;
   assign boot_count   = bcnt_q;

endmodule

// File: tb/tb_looper_boot_ctrl.sv
// Directed bench for looper_boot_ctrl: boot timing, debounced restarts, glitch rejection, mid-boot reset, saturation.
// Each boot's expected PC/count is queued at stimulus time and checked when boot_done rises.
`timescale 1ns/1ps
module tb_looper_boot_ctrl;

   localparam int              PC_W    = 15;
   localparam logic [PC_W-1:0] BOOT_PC = 15'h0010;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [7:0]      cnt;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            restart_btn;
   logic [PC_W-1:0] restart_pc;
   logic            core_rst_n;
   logic [PC_W-1:0] extern_pc;
   logic            extern_pc_en;
   logic            boot_done;
   logic [7:0]      boot_count;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic done_prev = 1'b0;
   logic [7:0] exp_cnt = 8'd0;

   looper_boot_ctrl #(
      .PC_W        (PC_W),
      .BOOT_PC     (BOOT_PC),
      .HOLD_CYCLES (16),
      .LOAD_CYCLES (2),
      .DB_CYCLES   (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .restart_btn  (restart_btn),
      .restart_pc   (restart_pc),
      .core_rst_n   (core_rst_n),
      .extern_pc    (extern_pc),
      .extern_pc_en (extern_pc_en),
      .boot_done    (boot_done),
      .boot_count   (boot_count)
   );

   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_boot(input logic [PC_W-1:0] pc);
      exp_t e;
      exp_cnt = (exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1;
      e.pc  = pc;
      e.cnt = exp_cnt;
      sb.push_back(e);
   endtask

   // Called at each negedge: a new boot completion pops the scoreboard.
   task automatic mon();
      exp_t e;
      if (boot_done === 1'b1 && done_prev !== 1'b1) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL boot_unexpected observed %0d queued required >0", sb.size());
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("boot_pc", 32'(extern_pc), 32'(e.pc));
            chk("boot_cnt", 32'(boot_count), 32'(e.cnt));
         end
      end
      done_prev = boot_done;
   endtask

   task automatic cycle();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_run(input int budget);
      int n = 0;
      while (boot_done !== 1'b1 && n < budget) begin
         cycle();
         n++;
      end
      chk("run_reached", 32'(boot_done), 32'd1);
   endtask

   // rst was just released; edge 0 is the next rising edge.
   task automatic check_boot_seq(input string tag);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk({tag, "_rst_n"}, 32'(core_rst_n), (k >= 16) ? 32'd1 : 32'd0);
         chk({tag, "_pc_en"}, 32'(extern_pc_en), (k == 16 || k == 17) ? 32'd1 : 32'd0);
         chk({tag, "_done"}, 32'(boot_done), (k >= 18) ? 32'd1 : 32'd0);
         chk({tag, "_pc"}, 32'(extern_pc), 32'(BOOT_PC));
         mon();
         @(posedge clk);
         #1;
      end
      chk({tag, "_count"}, 32'(boot_count), 32'd1);
   endtask

   task automatic press(input int width);
      restart_btn = 1'b1;
      repeat (width) cycle();
      restart_btn = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      restart_btn = 1'b0;
      restart_pc  = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_rst_n", 32'(core_rst_n), 32'd0);
      chk("rst_pc", 32'(extern_pc), 32'(BOOT_PC));
      chk("rst_pc_en", 32'(extern_pc_en), 32'd0);
      chk("rst_done", 32'(boot_done), 32'd0);
      chk("rst_count", 32'(boot_count), 32'd0);

      // 1: power-on boot
      rst = 1'b0;
      push_boot(BOOT_PC);
      check_boot_seq("boot1");

      // 2: clean restart; restart_pc changes after the trigger edge
      restart_pc = 15'h1234;
      push_boot(15'h1234);
      restart_btn = 1'b1;
      repeat (6) cycle();
      chk("r2_pre_done", 32'(boot_done), 32'd1);
      cycle();
      chk("r2_trig_rst_n", 32'(core_rst_n), 32'd0);
      chk("r2_trig_pc", 32'(extern_pc), 32'h1234);
      for (int t = 1; t <= 18; t++) begin
         cycle();
         if (t == 1) restart_pc = 15'h7fff;
         if (t == 3) restart_btn = 1'b0;
         if (t == 17) chk("r2_done_17", 32'(boot_done), 32'd0);
         if (t == 18) chk("r2_done_18", 32'(boot_done), 32'd1);
      end
      repeat (30) cycle();
      chk("r2_count", 32'(boot_count), 32'd2);
      chk("r2_sb_empty", 32'(sb.size()), 32'd0);

      // 3: glitches shorter than the debounce window
      for (int w = 1; w <= 3; w++) begin
         press(w);
         repeat (10) cycle();
      end
      chk("glitch_done", 32'(boot_done), 32'd1);
      chk("glitch_count", 32'(boot_count), 32'd2);
      chk("glitch_sb_empty", 32'(sb.size()), 32'd0);

      // 4: press landing in HOLD, held into RUN, must not fire
      restart_pc = 15'h0abc;
      push_boot(15'h0abc);
      press(6);
      cycle();
      chk("r4_trig_rst_n", 32'(core_rst_n), 32'd0);
      repeat (7) cycle();
      restart_btn = 1'b1;
      repeat (8) cycle();
      chk("r4_in_hold", 32'(core_rst_n), 32'd0);
      repeat (40) cycle();
      chk("r4_held_done", 32'(boot_done), 32'd1);
      chk("r4_held_count", 32'(boot_count), 32'd3);
      restart_btn = 1'b0;
      repeat (15) cycle();
      restart_pc = 15'h0555;
      push_boot(15'h0555);
      press(6);
      cycle();
      wait_run(40);
      repeat (30) cycle();
      chk("r4_count", 32'(boot_count), 32'd4);
      chk("r4_sb_empty", 32'(sb.size()), 32'd0);

      // 5: reset pulse during LOAD
      restart_pc = 15'h1234;
      press(6);
      cycle();
      repeat (16) cycle();
      chk("r5_in_load_en", 32'(extern_pc_en), 32'd1);
      chk("r5_in_load_pc", 32'(extern_pc), 32'h1234);
      rst = 1'b1;
      cycle();
      chk("r5_rst_rst_n", 32'(core_rst_n), 32'd0);
      chk("r5_rst_pc", 32'(extern_pc), 32'(BOOT_PC));
      chk("r5_rst_count", 32'(boot_count), 32'd0);
      chk("r5_rst_pc_en", 32'(extern_pc_en), 32'd0);
      rst = 1'b0;
      exp_cnt = 8'd0;
      push_boot(BOOT_PC);
      check_boot_seq("boot5");
      repeat (10) cycle();

      // 6: saturation of boot_count over 256 restarts
      for (int i = 1; i <= 256; i++) begin
         restart_pc = PC_W'($urandom_range(0, 32767));
         push_boot(restart_pc);
         press(6);
         cycle();
         wait_run(40);
         repeat (8) cycle();
         if (i >= 254) chk("sat_count", 32'(boot_count), (i >= 254) ? 32'hFF : 32'(i + 1));
      end
      repeat (20) cycle();
      chk("sat_final", 32'(boot_count), 32'hFF);
      chk("sat_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
